// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory responder and the CPU control FSM.
// Holds state encodings, default widths and the error-cause codes.
package mem_responder_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_ACCESS  = 3'd2,
    S_CAPTURE = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  // Error cause is a bit-set so that both faults can be reported at once.
  typedef logic [1:0] err_cause_t;
  localparam err_cause_t ERR_NONE        = 2'b00;
  localparam err_cause_t ERR_RANGE       = 2'b01;
  localparam err_cause_t ERR_FETCH_WRITE = 2'b10;

  typedef struct packed {
    state_t     state;
    err_cause_t cause;
    logic       fetch;
    logic       write;
    logic [3:0] wait_count;
  } dbg_t;

  function automatic err_cause_t err_cause(input logic out_of_range,
                                           input logic fetch,
                                           input logic write);
    err_cause_t c;
    c = ERR_NONE;
    if (out_of_range)    c = c | ERR_RANGE;
    if (fetch && write)  c = c | ERR_FETCH_WRITE;
    return c;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// CPU request/response and block-RAM port bundle for mem_responder.
// Handshake: a request transfers on a rising edge where req_valid and req_ready are both high;
// the requester holds every req_* signal stable until then. resp_valid is a one-cycle pulse with no back-pressure.
interface mem_responder_if
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic              req_fetch;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // The responder side.
  modport slave (
    input  req_valid, req_write, req_fetch, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  // The CPU plus RAM side.
  modport master (
    output req_valid, req_write, req_fetch, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_responder_wait_counter.sv
// 4-bit loadable down-counter used to time the wait states before a RAM access.
// Stops at zero rather than wrapping.
module mem_wait_counter (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic [3:0] count,
  output logic       zero
);

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one CPU fetch/load/store, optionally waits,
// drives the single-port synchronous RAM and returns exactly one response pulse.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int MEM_DEPTH   = 4096,
  parameter int WAIT_STATES = 0
) (
  input  logic            clock,
  input  logic            reset,
  mem_responder_if.slave  bus,
  output dbg_t            dbg
);

  generate
    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
      $error("mem_responder: WAIT_STATES must be within 0..15");
    end
  endgenerate

  // One extra bit so a depth equal to 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(MEM_DEPTH);
  localparam bit              HAS_WAIT  = (WAIT_STATES > 0);
  localparam logic [3:0]      WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t            state;
  state_t            state_n;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              write_q;
  logic              fetch_q;
  logic              err_q;
  err_cause_t        cause_q;

  err_cause_t        cause_in;
  logic              accept;
  logic              ctr_load;
  logic              ctr_dec;
  logic              ctr_zero;
  logic [3:0]        ctr_count;

  assign cause_in = err_cause(({1'b0, bus.req_addr} >= DEPTH_LIM), bus.req_fetch, bus.req_write);
  assign accept   = (state == S_IDLE) && bus.req_valid;

  mem_wait_counter u_wait (
    .clock    (clock),
    .reset    (reset),
    .load     (ctr_load),
    .load_val (WAIT_LOAD),
    .dec      (ctr_dec),
    .count    (ctr_count),
    .zero     (ctr_zero)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      write_q <= 1'b0;
      fetch_q <= 1'b0;
      err_q   <= 1'b0;
      cause_q <= ERR_NONE;
    end else begin
      state <= state_n;
      if (accept) begin
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        write_q <= bus.req_write;
        fetch_q <= bus.req_fetch;
        err_q   <= |cause_in;
        cause_q <= cause_in;
      end
      if (state == S_CAPTURE) begin
        rdata_q <= bus.mem_rdata;
      end
    end
  end

  // Faulting requests skip the wait states and the RAM entirely.
  always_comb begin
    state_n  = state;
    ctr_load = 1'b0;
    ctr_dec  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (|cause_in) begin
            state_n = S_RESP;
          end else if (HAS_WAIT) begin
            state_n  = S_WAIT;
            ctr_load = 1'b1;
          end else begin
            state_n = S_ACCESS;
          end
        end
      end
      S_WAIT: begin
        if (ctr_zero) state_n = S_ACCESS;
        else          ctr_dec = 1'b1;
      end
      S_ACCESS:  state_n = write_q ? S_RESP : S_CAPTURE;
      S_CAPTURE: state_n = S_RESP;
      S_RESP:    state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = (state == S_IDLE);
    bus.mem_en     = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.resp_valid = 1'b0;
    bus.resp_err   = 1'b0;
    bus.resp_rdata = '0;
    if (state == S_ACCESS) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = write_q;
      bus.mem_addr  = addr_q;
      bus.mem_wdata = wdata_q;
    end
    if (state == S_RESP) begin
      bus.resp_valid = 1'b1;
      bus.resp_err   = err_q;
      if (!err_q && !write_q) bus.resp_rdata = rdata_q;
    end
  end

  assign dbg.state      = state;
  assign dbg.cause      = cause_q;
  assign dbg.fetch      = fetch_q;
  assign dbg.write      = write_q;
  assign dbg.wait_count = ctr_count;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (0 and 3 wait states), a RAM per instance,
// a transaction-level model compared every cycle, plus directed literal checks.
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int DEPTH = 4096;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mem_responder_if #(.ADDR_W(16), .DATA_W(16)) if0 ();
  mem_responder_if #(.ADDR_W(16), .DATA_W(16)) if3 ();
  dbg_t dbg0;
  dbg_t dbg3;

  mem_responder #(.ADDR_W(16), .DATA_W(16), .MEM_DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
    .clock (clock), .reset (reset), .bus (if0.slave), .dbg (dbg0)
  );
  mem_responder #(.ADDR_W(16), .DATA_W(16), .MEM_DEPTH(DEPTH), .WAIT_STATES(3)) dut3 (
    .clock (clock), .reset (reset), .bus (if3.slave), .dbg (dbg3)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  typedef struct packed {
    logic ready, resp_valid, resp_err, mem_en, mem_we;
    logic [15:0] resp_rdata, mem_addr, mem_wdata;
  } obs_t;

  typedef struct packed {
    logic v, w, f;
    logic [15:0] a, d;
  } req_t;

  typedef struct {
    int en_at, n_en, rv_at, n_rv;
    logic [15:0] rd, addr, wd;
    logic er, we;
  } seen_t;

  function automatic logic [15:0] init_word(input int i);
    return 16'(i) ^ 16'hA5C3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic obs_t observe(input int k);
    obs_t o;
    if (k == 0) begin
      o.ready = if0.req_ready; o.resp_valid = if0.resp_valid; o.resp_err = if0.resp_err;
      o.mem_en = if0.mem_en; o.mem_we = if0.mem_we; o.resp_rdata = if0.resp_rdata;
      o.mem_addr = if0.mem_addr; o.mem_wdata = if0.mem_wdata;
    end else begin
      o.ready = if3.req_ready; o.resp_valid = if3.resp_valid; o.resp_err = if3.resp_err;
      o.mem_en = if3.mem_en; o.mem_we = if3.mem_we; o.resp_rdata = if3.resp_rdata;
      o.mem_addr = if3.mem_addr; o.mem_wdata = if3.mem_wdata;
    end
    return o;
  endfunction

  function automatic req_t req_in(input int k);
    req_t r;
    if (k == 0) r = '{if0.req_valid, if0.req_write, if0.req_fetch, if0.req_addr, if0.req_wdata};
    else        r = '{if3.req_valid, if3.req_write, if3.req_fetch, if3.req_addr, if3.req_wdata};
    return r;
  endfunction

  task automatic set_req(input int k, input logic v, input logic w, input logic f,
                         input logic [15:0] a, input logic [15:0] d);
    if (k == 0) begin
      if0.req_valid = v; if0.req_write = w; if0.req_fetch = f; if0.req_addr = a; if0.req_wdata = d;
    end else begin
      if3.req_valid = v; if3.req_write = w; if3.req_fetch = f; if3.req_addr = a; if3.req_wdata = d;
    end
  endtask

  task automatic next();
    @(negedge clock);
  endtask

  // Block RAMs: registered read, contents restored on reset.
  logic [15:0] ram0 [DEPTH];
  logic [15:0] ram3 [DEPTH];
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ram0[i] <= init_word(i);
        ram3[i] <= init_word(i);
      end
      if0.mem_rdata <= '0;
      if3.mem_rdata <= '0;
    end else begin
      if (if0.mem_en) begin
        if (if0.mem_we) ram0[if0.mem_addr[11:0]] <= if0.mem_wdata;
        else            if0.mem_rdata <= ram0[if0.mem_addr[11:0]];
      end
      if (if3.mem_en) begin
        if (if3.mem_we) ram3[if3.mem_addr[11:0]] <= if3.mem_wdata;
        else            if3.mem_rdata <= ram3[if3.mem_addr[11:0]];
      end
    end
  end

  // Transaction model: m_age counts cycles since the accept cycle (accept cycle = 0).
  bit          m_busy  [2];
  int          m_age   [2];
  bit          m_write [2];
  bit          m_err   [2];
  logic [15:0] m_addr  [2];
  logic [15:0] m_wdata [2];
  logic [15:0] m_rdata [2];
  logic [15:0] ref_mem [2][DEPTH];

  function automatic int ws(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  function automatic int lat(input int k);
    if (m_err[k]) return 1;
    return m_write[k] ? 2 + ws(k) : 3 + ws(k);
  endfunction

  always @(posedge clock) begin : model
    req_t r;
    for (int k = 0; k < 2; k++) begin
      r = req_in(k);
      if (reset) begin
        m_busy[k] = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[k][i] = init_word(i);
      end else if (m_busy[k]) begin
        if (!m_err[k] && m_age[k] == 1 + ws(k)) begin
          if (m_write[k]) ref_mem[k][m_addr[k][11:0]] = m_wdata[k];
          else            m_rdata[k] = ref_mem[k][m_addr[k][11:0]];
        end
        if (m_age[k] >= lat(k)) m_busy[k] = 1'b0;
        else                    m_age[k]++;
      end else if (r.v) begin
        m_busy[k]  = 1'b1;
        m_age[k]   = 1;
        m_write[k] = r.w;
        m_addr[k]  = r.a;
        m_wdata[k] = r.d;
        m_rdata[k] = '0;
        m_err[k]   = (int'(r.a) >= DEPTH) || (r.f && r.w);
      end
    end
  end

  always @(negedge clock) begin : compare
    obs_t o;
    bit e_en, e_we, e_rv;
    logic [15:0] e_rd;
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        o    = observe(k);
        e_rv = m_busy[k] && (m_age[k] == lat(k));
        e_en = m_busy[k] && !m_err[k] && (m_age[k] == 1 + ws(k));
        e_we = e_en && m_write[k];
        e_rd = (e_rv && !m_err[k] && !m_write[k]) ? m_rdata[k] : 16'h0;
        check($sformatf("u%0d req_ready", k),  32'(o.ready),      32'(!m_busy[k]));
        check($sformatf("u%0d resp_valid", k), 32'(o.resp_valid), 32'(e_rv));
        check($sformatf("u%0d resp_err", k),   32'(o.resp_err),   32'(e_rv && m_err[k]));
        check($sformatf("u%0d resp_rdata", k), 32'(o.resp_rdata), 32'(e_rd));
        check($sformatf("u%0d mem_en", k),     32'(o.mem_en),     32'(e_en));
        check($sformatf("u%0d mem_we", k),     32'(o.mem_we),     32'(e_we));
        if (e_en) check($sformatf("u%0d mem_addr", k),  32'(o.mem_addr),  32'(m_addr[k]));
        if (e_we) check($sformatf("u%0d mem_wdata", k), 32'(o.mem_wdata), 32'(m_wdata[k]));
      end
    end
  end

  // Presents a request, waits (bounded) for the accept cycle T, returns at cycle T+1.
  // Unless held, the request is dropped and its fields scrambled after the accept.
  task automatic issue(input int k, input logic w, input logic f, input logic [15:0] a,
                       input logic [15:0] d, input bit hold, output int t);
    obs_t o;
    set_req(k, 1'b1, w, f, a, d);
    t = -1;
    for (int i = 0; i < 64; i++) begin
      o = observe(k);
      if (o.ready) begin
        t = cyc;
        break;
      end
      next();
    end
    check($sformatf("u%0d accept within bound", k), 32'(t >= 0), 32'd1);
    next();
    if (!hold) set_req(k, 1'b0, ~w, ~f, 16'hFFFF, 16'h1234);
  endtask

  // Observes n cycles starting at T+1; positions are relative to T.
  task automatic watch(input int k, input int n, output seen_t s);
    obs_t o;
    s = '{0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0};
    for (int i = 1; i <= n; i++) begin
      o = observe(k);
      if (o.mem_en) begin
        if (s.n_en == 0) begin
          s.en_at = i; s.addr = o.mem_addr; s.wd = o.mem_wdata; s.we = o.mem_we;
        end
        s.n_en++;
      end
      if (o.resp_valid) begin
        if (s.n_rv == 0) begin
          s.rv_at = i; s.rd = o.resp_rdata; s.er = o.resp_err;
        end
        s.n_rv++;
      end
      next();
    end
  endtask

  initial begin : stimulus
    int t, t2;
    seen_t s;
    obs_t o;
    set_req(0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    set_req(1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    reset = 1'b1;
    repeat (3) next();
    reset = 1'b0;
    chk_en = 1'b1;

    for (int k = 0; k < 2; k++) begin
      o = observe(k);
      check("reset req_ready", 32'(o.ready), 32'd1);
      check("reset resp_valid", 32'(o.resp_valid), 32'd0);
      check("reset mem_en", 32'(o.mem_en), 32'd0);
      check("reset mem_addr", 32'(o.mem_addr), 32'd0);
      check("reset mem_wdata", 32'(o.mem_wdata), 32'd0);
      check("reset resp_rdata", 32'(o.resp_rdata), 32'd0);
    end
    check("reset u0 state", 32'(dbg0.state), 32'(S_IDLE));
    check("reset u3 state", 32'(dbg3.state), 32'(S_IDLE));

    // W=0 store then fetch-read of the same word
    issue(0, 1'b1, 1'b0, 16'h0010, 16'hBEEF, 1'b0, t);
    watch(0, 4, s);
    check("w0 store mem_en at", 32'(s.en_at), 32'd1);
    check("w0 store mem_we", 32'(s.we), 32'd1);
    check("w0 store mem_addr", 32'(s.addr), 32'h0010);
    check("w0 store mem_wdata", 32'(s.wd), 32'hBEEF);
    check("w0 store resp at", 32'(s.rv_at), 32'd2);
    check("w0 store pulses", 32'(s.n_rv), 32'd1);
    check("w0 store resp_err", 32'(s.er), 32'd0);
    check("w0 store resp_rdata", 32'(s.rd), 32'd0);

    issue(0, 1'b0, 1'b1, 16'h0010, 16'h0000, 1'b0, t);
    watch(0, 5, s);
    check("w0 fetch mem_en at", 32'(s.en_at), 32'd1);
    check("w0 fetch mem_we", 32'(s.we), 32'd0);
    check("w0 fetch resp at", 32'(s.rv_at), 32'd3);
    check("w0 fetch rdata", 32'(s.rd), 32'hBEEF);

    // W=3 read, store, read-back
    issue(1, 1'b0, 1'b0, 16'h0002, 16'h0000, 1'b0, t);
    watch(1, 9, s);
    check("w3 read mem_en at", 32'(s.en_at), 32'd4);
    check("w3 read mem_en cycles", 32'(s.n_en), 32'd1);
    check("w3 read resp at", 32'(s.rv_at), 32'd6);
    check("w3 read pulses", 32'(s.n_rv), 32'd1);
    check("w3 read rdata", 32'(s.rd), 32'hA5C1);

    issue(1, 1'b1, 1'b0, 16'h0020, 16'h1357, 1'b0, t);
    watch(1, 7, s);
    check("w3 store mem_en at", 32'(s.en_at), 32'd4);
    check("w3 store resp at", 32'(s.rv_at), 32'd5);
    issue(1, 1'b0, 1'b0, 16'h0020, 16'h0000, 1'b0, t);
    watch(1, 8, s);
    check("w3 readback rdata", 32'(s.rd), 32'h1357);

    // Faults: out of range, fetch with write, and out of range with wait states
    issue(0, 1'b0, 1'b0, 16'h1000, 16'h0000, 1'b0, t);
    check("range cause", 32'(dbg0.cause), 32'(ERR_RANGE));
    watch(0, 4, s);
    check("range resp at", 32'(s.rv_at), 32'd1);
    check("range resp_err", 32'(s.er), 32'd1);
    check("range rdata", 32'(s.rd), 32'd0);
    check("range mem_en cycles", 32'(s.n_en), 32'd0);

    issue(0, 1'b1, 1'b1, 16'h0005, 16'h4444, 1'b0, t);
    check("fetchwr cause", 32'(dbg0.cause), 32'(ERR_FETCH_WRITE));
    watch(0, 4, s);
    check("fetchwr resp at", 32'(s.rv_at), 32'd1);
    check("fetchwr resp_err", 32'(s.er), 32'd1);
    check("fetchwr mem_en cycles", 32'(s.n_en), 32'd0);
    issue(0, 1'b0, 1'b0, 16'h0005, 16'h0000, 1'b0, t);
    watch(0, 5, s);
    check("fetchwr word untouched", 32'(s.rd), 32'hA5C6);
    check("fetchwr readback err", 32'(s.er), 32'd0);

    issue(1, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 1'b0, t);
    watch(1, 5, s);
    check("w3 range resp at", 32'(s.rv_at), 32'd1);
    check("w3 range mem_en cycles", 32'(s.n_en), 32'd0);

    // Last valid word, then two reads with req_valid held throughout
    issue(0, 1'b1, 1'b0, 16'h0FFF, 16'h7E57, 1'b0, t);
    watch(0, 4, s);
    check("top word store err", 32'(s.er), 32'd0);
    issue(0, 1'b0, 1'b0, 16'h0FFF, 16'h0000, 1'b1, t);
    for (int i = 1; i <= 3; i++) begin
      o = observe(0);
      check("b2b ready low", 32'(o.ready), 32'd0);
      if (i == 3) check("b2b first resp", 32'(o.resp_valid), 32'd1);
      next();
    end
    issue(0, 1'b0, 1'b0, 16'h0FFF, 16'h0000, 1'b0, t2);
    check("b2b second accept", 32'(t2 - t), 32'd4);
    watch(0, 5, s);
    check("b2b second rdata", 32'(s.rd), 32'h7E57);

    // Reset while in WAIT drops the transaction
    issue(1, 1'b0, 1'b0, 16'h0003, 16'h0000, 1'b0, t);
    next();
    reset = 1'b1;
    next();
    reset = 1'b0;
    o = observe(1);
    check("mid reset state", 32'(dbg3.state), 32'(S_IDLE));
    check("mid reset ready", 32'(o.ready), 32'd1);
    check("mid reset resp_valid", 32'(o.resp_valid), 32'd0);
    check("mid reset mem_en", 32'(o.mem_en), 32'd0);
    watch(1, 6, s);
    check("mid reset no pulse", 32'(s.n_rv), 32'd0);
    check("mid reset no mem_en", 32'(s.n_en), 32'd0);
    issue(1, 1'b0, 1'b0, 16'h0004, 16'h0000, 1'b0, t);
    watch(1, 8, s);
    check("after reset resp at", 32'(s.rv_at), 32'd6);
    check("after reset rdata", 32'(s.rd), 32'hA5C7);

    repeat (2) next();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
